// File: rtl/m_trap_ctrl.sv
// Machine-mode trap controller: M-only trap CSRs, exception/interrupt arbitration,
// trap entry / MRET sequencing and PC redirect handshake. Optional mtval via TRAP_MTVAL_EN.
module m_trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter bit          MEIP_SYNC   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        boundary,
  input  logic        mret_req,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_MRET, S_REDIR} state_e;

  state_e      state_q, state_d;
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [2:0]  mie_q, mie_d;           // {MEIE, MTIE, MSIE}
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        trap_irq_q, trap_irq_d;
  logic [4:0]  trap_code_q, trap_code_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] mtval_rd;
  logic        meip_s;

  generate
    if (MEIP_SYNC) begin : g_meip_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], meip_in};
      end
      assign meip_s = sync_q[1];
    end else begin : g_meip_raw
      assign meip_s = meip_in;
    end
  endgenerate

  logic [2:0]  mip;      // {MEIP, MTIP, MSIP}
  logic [2:0]  irq_pend;
  logic [4:0]  irq_code;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;

  assign mip      = {meip_s, mtip_in, msip_in};
  assign irq_pend = mip & mie_q & {3{st_mie_q}};

  // MEI > MSI > MTI
  always_comb begin
    irq_code = 5'd7;
    if (irq_pend[2])      irq_code = 5'd11;
    else if (irq_pend[0]) irq_code = 5'd3;
  end

  // Only mode 01 vectors, and only for interrupts; the add wraps at 32 bits.
  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_target = (trap_irq_q && mtvec_q[1:0] == 2'b01)
                     ? mtvec_base + {25'd0, trap_code_q, 2'b00}
                     : mtvec_base;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
  assign wr_mstatus = csr_we && csr_addr == A_MSTATUS;
  assign wr_mie     = csr_we && csr_addr == A_MIE;
  assign wr_mtvec   = csr_we && csr_addr == A_MTVEC;
  assign wr_mepc    = csr_we && csr_addr == A_MEPC;
  assign wr_mcause  = csr_we && csr_addr == A_MCAUSE;

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] trap_tval_q, trap_tval_d;
  logic        wr_mtval;
  assign wr_mtval = csr_we && csr_addr == A_MTVAL;
  assign mtval_rd = mtval_q;

  always_comb begin
    mtval_d     = mtval_q;
    trap_tval_d = trap_tval_q;
    if (wr_mtval) mtval_d = csr_wdata;
    if (state_q == S_IDLE && exc_req)  trap_tval_d = exc_tval;
    else if (state_q == S_IDLE)        trap_tval_d = 32'd0;
    if (state_q == S_ENTER) mtval_d = trap_irq_q ? 32'd0 : trap_tval_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtval_q     <= 32'd0;
      trap_tval_q <= 32'd0;
    end else begin
      mtval_q     <= mtval_d;
      trap_tval_q <= trap_tval_d;
    end
  end
`else
  logic unused_tval;
  assign unused_tval = ^exc_tval;
  assign mtval_rd    = 32'd0;
`endif

  // CSR writes first; FSM hardware updates override them on collision.
  always_comb begin
    state_d     = state_q;
    st_mie_d    = st_mie_q;
    st_mpie_d   = st_mpie_q;
    mie_d       = mie_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    redir_pc_d  = redir_pc_q;
    trap_irq_d  = trap_irq_q;
    trap_code_d = trap_code_q;
    trap_pc_d   = trap_pc_q;

    if (wr_mstatus) begin
      st_mie_d  = csr_wdata[3];
      st_mpie_d = csr_wdata[7];
    end
    if (wr_mie)    mie_d    = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
    if (wr_mtvec)  mtvec_d  = csr_wdata;
    if (wr_mepc)   mepc_d   = {csr_wdata[31:2], 2'b00};
    if (wr_mcause) mcause_d = csr_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          trap_irq_d  = 1'b0;
          trap_code_d = exc_code;
          trap_pc_d   = exc_pc;
          state_d     = S_ENTER;
        end else if (boundary && |irq_pend) begin
          trap_irq_d  = 1'b1;
          trap_code_d = irq_code;
          trap_pc_d   = exc_pc;
          state_d     = S_ENTER;
        end else if (mret_req) begin
          state_d = S_MRET;
        end
      end
      S_ENTER: begin
        mepc_d     = {trap_pc_q[31:2], 2'b00};
        mcause_d   = {trap_irq_q, 26'd0, trap_code_q};
        st_mpie_d  = st_mie_q;
        st_mie_d   = 1'b0;
        redir_pc_d = trap_target;
        state_d    = S_REDIR;
      end
      S_MRET: begin
        st_mie_d   = st_mpie_q;
        st_mpie_d  = 1'b1;
        redir_pc_d = mepc_q;
        state_d    = S_REDIR;
      end
      S_REDIR: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_mie_q    <= 1'b0;
      st_mpie_q   <= 1'b0;
      mie_q       <= 3'b000;
      mtvec_q     <= RESET_MTVEC;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
      redir_pc_q  <= 32'd0;
      trap_irq_q  <= 1'b0;
      trap_code_q <= 5'd0;
      trap_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      st_mie_q    <= st_mie_d;
      st_mpie_q   <= st_mpie_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      redir_pc_q  <= redir_pc_d;
      trap_irq_q  <= trap_irq_d;
      trap_code_q <= trap_code_d;
      trap_pc_q   <= trap_pc_d;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    unique case (csr_addr)
      A_MSTATUS: csr_rdata = {19'd0, 2'b11, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
      A_MIE:     csr_rdata = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MTVAL:   csr_rdata = mtval_rd;
      A_MIP:     csr_rdata = {20'd0, mip[2], 3'd0, mip[1], 3'd0, mip[0], 3'd0};
      default:   csr_rdata = 32'd0;
    endcase
  end

  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = redir_pc_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Directed bench for m_trap_ctrl: expected redirect targets go into a queue,
// a negedge monitor pops and compares on every redirect handshake.
module tb_m_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        boundary = 1'b0;
  logic        mret_req = 1'b0;
  logic        meip_in = 1'b0, mtip_in = 1'b0, msip_in = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b1;
  logic        busy;

`ifdef TRAP_MTVAL_EN
  localparam bit MTVAL = 1'b1;
`else
  localparam bit MTVAL = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  logic [31:0] exp_q[$];

  m_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .boundary(boundary), .mret_req(mret_req),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (rst_n && redirect_valid && redirect_ready) begin
      xfers++;
      if (exp_q.size() == 0) chk("unexpected_redirect", redirect_pc, 32'hxxxx_xxxx);
      else chk("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_we = 1'b1; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a; #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xf0;
    logic seen;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    csr_chk("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_chk("rst_mtvec", 12'h305, 32'h0);
    csr_chk("rst_mcause", 12'h342, 32'h0);

    // register rules
    csr_write(12'h300, 32'hFFFF_FFFF); csr_chk("mstatus_mask", 12'h300, 32'h0000_1888);
    csr_write(12'h300, 32'h0);         csr_chk("mstatus_clr", 12'h300, 32'h0000_1800);
    csr_write(12'h341, 32'h103);       csr_chk("mepc_align", 12'h341, 32'h100);
    csr_write(12'h304, 32'hFFFF_FFFF); csr_chk("mie_mask", 12'h304, 32'h888);
    csr_write(12'h344, 32'hFFFF_FFFF); csr_chk("mip_ro", 12'h344, 32'h0);
    csr_write(12'h343, 32'h1234);      csr_chk("mtval_wr", 12'h343, MTVAL ? 32'h1234 : 32'h0);
    csr_chk("unmapped", 12'h123, 32'h0);
    csr_write(12'h304, 32'h0);

    // direct-mode exception, latency, and colliding mcause write
    csr_write(12'h305, 32'h0000_1000);
    csr_write(12'h300, 32'h8);
    exc_req = 1; exc_code = 5'd2; exc_pc = 32'h80; exc_tval = 32'h55;
    exp_q.push_back(32'h1000);
    tick();
    exc_req = 0;
    chk("lat1_valid", {31'd0, redirect_valid}, 32'd0);
    chk("lat1_busy", {31'd0, busy}, 32'd1);
    csr_addr = 12'h342; csr_we = 1; csr_wdata = 32'hDEAD;
    tick();
    csr_we = 0;
    chk("lat2_valid", {31'd0, redirect_valid}, 32'd1);
    wait_idle();
    csr_chk("exc_mepc", 12'h341, 32'h80);
    csr_chk("exc_mcause", 12'h342, 32'h2);
    csr_chk("exc_mstatus", 12'h300, 32'h0000_1880);
    csr_chk("exc_mtval", 12'h343, MTVAL ? 32'h55 : 32'h0);

    // vectored timer interrupt
    csr_write(12'h305, 32'h0000_2001);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    mtip_in = 1; boundary = 1; exc_pc = 32'h200;
    exp_q.push_back(32'h201C);
    tick();
    boundary = 0;
    chk("tmr_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    csr_chk("tmr_mip", 12'h344, 32'h80);
    mtip_in = 0;
    csr_chk("tmr_mcause", 12'h342, 32'h8000_0007);
    csr_chk("tmr_mepc", 12'h341, 32'h200);
    csr_chk("tmr_mtval", 12'h343, 32'h0);

    // all three pending: MEI wins; then MRET
    csr_write(12'h305, 32'h0000_3000);
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    meip_in = 1; msip_in = 1; mtip_in = 1;
    tick(); tick(); tick();
    csr_chk("all_mip", 12'h344, 32'h888);
    boundary = 1; exc_pc = 32'h300;
    exp_q.push_back(32'h3000);
    tick();
    boundary = 0; meip_in = 0; msip_in = 0; mtip_in = 0;
    wait_idle();
    csr_chk("mei_mcause", 12'h342, 32'h8000_000B);
    mret_req = 1;
    exp_q.push_back(32'h300);
    tick();
    mret_req = 0;
    wait_idle();
    csr_chk("mret_mstatus", 12'h300, 32'h0000_1888);

    // MSI beats MTI, vectored
    csr_write(12'h305, 32'h0000_3001);
    csr_write(12'h304, 32'h88);
    msip_in = 1; mtip_in = 1; boundary = 1; exc_pc = 32'h400;
    exp_q.push_back(32'h300C);
    tick();
    boundary = 0; msip_in = 0; mtip_in = 0;
    wait_idle();
    csr_chk("msi_mcause", 12'h342, 32'h8000_0003);

    // vectored target wraps modulo 2^32
    csr_write(12'h305, 32'hFFFF_FFF1);
    csr_write(12'h304, 32'h800);
    csr_write(12'h300, 32'h8);
    meip_in = 1;
    tick(); tick(); tick();
    boundary = 1;
    exp_q.push_back(32'h0000_001C);
    tick();
    boundary = 0; meip_in = 0;
    wait_idle();

    // masking by mstatus.MIE
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h80);
    mtip_in = 1; boundary = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= busy; end
    chk("mask_busy", {31'd0, seen}, 32'd0);
    boundary = 0; mtip_in = 0;

    // backpressure
    csr_write(12'h305, 32'h0000_4000);
    xf0 = xfers;
    redirect_ready = 0;
    exc_req = 1; exc_code = 5'd5; exc_pc = 32'h44; exc_tval = 32'h77;
    exp_q.push_back(32'h4000);
    tick();
    exc_req = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      exc_req = (i == 2); exc_code = 5'd9; exc_pc = 32'h99;
      tick();
      chk("bp_valid", {31'd0, redirect_valid}, 32'd1);
      chk("bp_pc", redirect_pc, 32'h4000);
    end
    exc_req = 0;
    redirect_ready = 1;
    tick();
    tick();
    chk("bp_busy", {31'd0, busy}, 32'd0);
    chk("bp_xfers", xfers - xf0, 32'd1);
    csr_chk("bp_mcause", 12'h342, 32'h5);
    csr_chk("bp_mepc", 12'h341, 32'h44);

    // reset while in REDIR
    redirect_ready = 0;
    exc_req = 1; exc_code = 5'd1; exc_pc = 32'h88;
    tick();
    exc_req = 0;
    tick();
    chk("pre_rst_valid", {31'd0, redirect_valid}, 32'd1);
    rst_n = 0; #1;
    chk("rst_mid_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rpc", redirect_pc, 32'd0);
    csr_chk("rst_mid_mepc", 12'h341, 32'h0);
    redirect_ready = 1;
    tick();
    rst_n = 1;
    tick(); tick();
    chk("post_rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("pending_redirects", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m_trap_ctrl.md
Name: m_trap_ctrl

Overview:
- Machine-mode trap controller, directly downstream of the CSR type definitions; holds the M-only trap CSRs (mstatus MIE/MPIE/MPP, mie, mtvec, mepc, mcause, mtval).
- Arbitrates exceptions against pending interrupts and sequences trap entry and MRET.
- Issues a PC redirect handshake to the core front-end.
- Sits beside the core's execute stage.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec (base and mode fields).
- MEIP_SYNC, 1, 1 = pass the meip input through a 2-flop synchronizer; 0 = use it directly.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address
- csr_we  in  1  CSR write strobe
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  combinational read data; 0 for unmapped addresses
- exc_req  in  1  exception from the retiring instruction
- exc_code  in  5  exception cause code
- exc_pc  in  32  PC of the faulting or boundary instruction
- exc_tval  in  32  trap value (see Optional Feature)
- boundary  in  1  core is at an instruction boundary and may take an interrupt
- mret_req  in  1  MRET retiring
- meip_in, mtip_in, msip_in  in  1 each  raw interrupt lines
- redirect_valid  out  1  new PC is valid
- redirect_pc  out  32  target PC
- redirect_ready  in  1  front-end accepts the redirect
- busy  out  1  FSM not in IDLE; the core must stall retirement while high

Behaviour:
- Reset values:
  - mstatus.MIE = 0, MPIE = 0; mie = 0; mtvec = RESET_MTVEC; mepc, mcause, mtval = 0.
  - redirect_valid = 0, redirect_pc = 0, busy = 0, FSM = IDLE, synchronizer flops = 0.
- CSR map:
  - 0x300 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 2'b11; all other bits read 0.
  - 0x304 mie: bits 11, 7, 3 writable; others read 0.
  - 0x305 mtvec: fully writable; mode 2'b10 and 2'b11 behave as direct.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause: writable.
  - 0x343 mtval: writable.
  - 0x344 mip: read-only; returns {meip,mtip,msip} at bits 11/7/3; writes ignored.
- CSR write timing: writes take effect on the next rising edge.
- Interrupt eligibility and priority:
  - pending = mip & mie, gated by mstatus.MIE.
  - Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- FSM states: IDLE, ENTER, MRET, REDIR.
- IDLE transitions (priority order):
  1. exc_req -> ENTER with an exception.
  2. Else boundary and any eligible interrupt -> ENTER with that interrupt.
  3. Else mret_req -> MRET.
  - exc_req and mret_req together: the exception wins.
- ENTER (1 cycle):
  - mepc <= exc_pc; mcause <= {irq, 26'b0, code}.
  - MPIE <= MIE; MIE <= 0.
  - mtval <= exc_tval for exceptions, 0 for interrupts.
  - redirect_pc:
    - exceptions, or direct mode: {mtvec.base, 2'b00}
    - interrupts in vectored mode (mode 01): {mtvec.base, 2'b00} + 4*code
  - Then -> REDIR.
- MRET (1 cycle): MIE <= MPIE; MPIE <= 1; redirect_pc <= mepc; then -> REDIR.
- REDIR:
  - redirect_valid = 1; redirect_pc is held stable until redirect_ready.
  - On valid & ready: -> IDLE, redirect_valid deasserts next cycle.
  - Minimum latency from request to redirect_valid = 2 cycles.
- Request inputs are sampled only in IDLE; they are ignored while busy.
- CSR write colliding with ENTER/MRET updates of the same register: the hardware update wins and the CSR write is dropped.
- Vectored target address arithmetic wraps modulo 2^32.
- Reset asserted mid-sequence: immediate return to IDLE with all reset values; no partial redirect.

Optional Feature:
- Macro TRAP_MTVAL_EN.
- Defined: mtval is implemented as above.
- Undefined: no mtval register; 0x343 reads 0, writes ignored, exc_tval unused.

Test Plan:
- Direct-mode exception: mtvec=0x0000_1000, exc_req, exc_code=2, exc_pc=0x80 -> mepc=0x80, mcause=0x0000_0002, MIE cleared, redirect_pc=0x1000 two cycles later.
- Vectored timer interrupt: mtvec=0x0000_2001, mie=0x80, MIE=1, mtip_in=1, boundary -> mcause=0x8000_0007, redirect_pc=0x201C.
- Simultaneous meip, msip, mtip all enabled -> mcause=0x8000_000B; after MRET, MIE=1 and redirect_pc=mepc.
- Masking: mtip_in=1, mie=0x80, MIE=0, boundary held for 20 cycles -> no trap, busy stays 0.
- Backpressure: redirect_ready held low 5 cycles -> redirect_valid and redirect_pc stable; one transfer only; exc_req pulsed during REDIR is ignored.
- Register rules: write mstatus=0xFFFF_FFFF -> read 0x0000_1888; write mepc=0x103 -> read 0x100; assert rst_n low in REDIR -> redirect_valid=0 immediately.
